// File: rtl/fetch_stage_buffered.sv
// Instruction fetch stage: one memory request per accepted PC, results queued in an in-order FIFO toward decode.
// Latency 2 cycles accept->done_next with 1-cycle memory; slot reservation stalls the PC stage before the FIFO can overflow.
module fetch_stage_buffered #(
    parameter int ADDR_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int BUF_DEPTH         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    output logic                         stall_prev,
    input  logic                         prev_done,
    input  logic                         next_stall,
    output logic                         done_next,
    output logic [ADDR_WIDTH-1:0]        instruction_addr,
    output logic                         instruction_fetch_activate,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_data,
    input  logic                         instruction_fetch_done,
    input  logic [ADDR_WIDTH-1:0]        program_count_in,
    input  logic                         program_count_valid_in,
    output logic [ADDR_WIDTH-1:0]        program_count_out,
    output logic                         program_count_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
    output logic                         instruction_data_valid_out
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]        pc;
        logic                         pcv;
        logic [INSTRUCTION_WIDTH-1:0] ins;
        logic                         iv;
    } entry_t;

    // Request register
    logic [ADDR_WIDTH-1:0] req_pc_q,   req_pc_d;
    logic                  req_pcv_q,  req_pcv_d;
    logic                  req_busy_q, req_busy_d;

    // Result FIFO
    entry_t            buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q,  head_d;
    logic [PTR_W-1:0]  tail_q,  tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              complete;
    logic              push;
    logic              pop;
    logic              transfer_prev;
    logic              fifo_empty;
    logic [OCC_W-1:0]  occupancy;
    entry_t            push_entry;
    entry_t            head_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Bubbles have nothing to wait for, so they complete as soon as they are held.
    assign complete   = req_busy_q && (req_pcv_q ? instruction_fetch_done : 1'b1);
    assign push       = complete && !flush && !rst;
    assign fifo_empty = (count_q == '0);
    assign done_next  = !rst && !flush && !fifo_empty;
    assign pop        = done_next && !next_stall;

    // Entries held plus the one in flight must leave a free slot before another PC is taken.
    assign occupancy     = OCC_W'(count_q) + OCC_W'(req_busy_q) - OCC_W'(pop);
    assign stall_prev    = rst || flush || (req_busy_q && !complete) ||
                           (occupancy >= OCC_W'(BUF_DEPTH));
    assign transfer_prev = prev_done && !stall_prev;

    assign instruction_fetch_activate = req_busy_q && req_pcv_q && !flush && !rst;
    assign instruction_addr           = req_busy_q ? req_pc_q : '0;

    always_comb begin
        push_entry     = '0;
        push_entry.pc  = req_pc_q;
        push_entry.pcv = req_pcv_q;
        push_entry.ins = req_pcv_q ? instruction_data : '0;
        push_entry.iv  = req_pcv_q;
    end

    always_comb begin
        req_pc_d   = req_pc_q;
        req_pcv_d  = req_pcv_q;
        req_busy_d = req_busy_q;
        if (flush) begin
            req_busy_d = 1'b0;
        end else if (transfer_prev) begin
            req_pc_d   = program_count_in;
            req_pcv_d  = program_count_valid_in;
            req_busy_d = 1'b1;
        end else if (complete) begin
            req_busy_d = 1'b0;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q   <= '0;
            req_pcv_q  <= 1'b0;
            req_busy_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            req_pc_q   <= req_pc_d;
            req_pcv_q  <= req_pcv_d;
            req_busy_q <= req_busy_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[tail_q] <= push_entry;
        end
    end

    // Data outputs stay at zero whenever nothing is queued.
    assign head_entry = fifo_empty ? '0 : buf_q[head_q];

    assign program_count_out          = head_entry.pc;
    assign program_count_valid_out    = head_entry.pcv;
    assign instruction_data_out       = head_entry.ins;
    assign instruction_data_valid_out = head_entry.iv;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CNT_W'(BUF_DEPTH))));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(BUF_DEPTH));

endmodule

// File: tb/tb_fetch_stage_buffered.sv
// Scoreboard bench for fetch_stage_buffered: accepted PCs form the expected in-order stream,
// a memory model answers requests, and a negedge monitor checks every emitted entry and memory request.
module tb_fetch_stage_buffered;

    localparam int DEPTH = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic        pcv;
        logic [31:0] ins;
        logic        iv;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, prev_done, next_stall;
    logic        stall_prev, done_next, act, mem_done;
    logic [31:0] addr, mem_data, pc_in, pc_out, ins_out;
    logic        pcv_in, pcv_out, iv_out;

    int   checks = 0, errors = 0, cyc = 0;
    ent_t        exp_q[$];
    logic [31:0] fetch_q[$];
    int          emit_cyc[$];
    ent_t        tmp_ent;
    logic [31:0] tmp_pc;

    logic        act_prev = 1'b0, done_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    int          run_len = 0, last_run = 0, act_done_cnt = 0;
    int          mem_lat = 1, mem_wait = 0;
    bit          mem_rand = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_stage_buffered #(.ADDR_WIDTH(32), .INSTRUCTION_WIDTH(32), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_prev(stall_prev), .prev_done(prev_done),
        .next_stall(next_stall), .done_next(done_next), .instruction_addr(addr),
        .instruction_fetch_activate(act), .instruction_data(mem_data),
        .instruction_fetch_done(mem_done), .program_count_in(pc_in),
        .program_count_valid_in(pcv_in), .program_count_out(pc_out),
        .program_count_valid_out(pcv_out), .instruction_data_out(ins_out),
        .instruction_data_valid_out(iv_out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A00_0013;
    endfunction

    function automatic ent_t model(input logic [31:0] pc, input logic v);
        ent_t e;
        e.pc  = pc;
        e.pcv = v;
        e.ins = v ? mem_word(pc) : 32'h0;
        e.iv  = v;
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, got no progress expected completion", name);
    endtask

    // Memory: answers after mem_lat activate cycles (or randomly); answers blindly during flush.
    initial begin
        logic a_s, d_s;
        mem_done = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            a_s = act;
            d_s = mem_done;
            @(posedge clk);
            #2;
            if (a_s && !d_s) mem_wait++;
            else mem_wait = 0;
            if (flush) begin
                mem_done = 1'b1;
                mem_data = 32'hDEAD_BEEF;
            end else if (mem_rand) begin
                mem_done = act && ($urandom_range(0, 2) != 0);
                mem_data = mem_word(addr);
            end else begin
                mem_done = act && (mem_wait + 1 >= mem_lat);
                mem_data = mem_word(addr);
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_stall_prev", 128'(stall_prev), 128'(1));
            chk("rst_done_next", 128'(done_next), 128'(0));
            chk("rst_activate", 128'(act), 128'(0));
            exp_q.delete();
            fetch_q.delete();
            run_len = 0;
            act_prev = 1'b0;
        end else if (flush) begin
            chk("flush_stall_prev", 128'(stall_prev), 128'(1));
            chk("flush_done_next", 128'(done_next), 128'(0));
            chk("flush_activate", 128'(act), 128'(0));
            exp_q.delete();
            fetch_q.delete();
            run_len = 0;
            act_prev = 1'b0;
        end else begin
            if (act) begin
                run_len++;
                if (act_prev && !done_prev) chk("addr_stable", 128'(addr), 128'(addr_prev));
                if (mem_done) begin
                    act_done_cnt++;
                    last_run = run_len;
                    run_len = 0;
                    if (fetch_q.size() == 0) begin
                        chk("unexpected_fetch", 128'(addr), 128'hFFFF_FFFF_FFFF);
                    end else begin
                        tmp_pc = fetch_q.pop_front();
                        chk("fetch_addr", 128'(addr), 128'(tmp_pc));
                    end
                end
            end else begin
                run_len = 0;
            end
            if (done_next) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry", 128'(pc_out), 128'hFFFF_FFFF_FFFF);
                end else begin
                    chk("head_entry", 128'({pc_out, pcv_out, ins_out, iv_out}), 128'(exp_q[0]));
                    if (!next_stall) begin
                        tmp_ent = exp_q.pop_front();
                        emit_cyc.push_back(cyc);
                    end
                end
            end else begin
                chk("empty_outputs_zero", 128'({pc_out, pcv_out, ins_out, iv_out}), 128'(0));
            end
            if (prev_done && !stall_prev) begin
                exp_q.push_back(model(pc_in, pcv_in));
                if (pcv_in) fetch_q.push_back(pc_in);
            end
            act_prev = act;
        end
        done_prev = mem_done;
        addr_prev = addr;
    end

    task automatic send(input logic [31:0] pc, input logic v);
        int  n;
        bit  acc;
        n = 0;
        prev_done = 1'b1;
        pc_in     = pc;
        pcv_in    = v;
        forever begin
            @(negedge clk);
            acc = !stall_prev;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                fail_bound("send");
                break;
            end
        end
        prev_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        prev_done = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) fail_bound(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, a0;
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, a0;
        rst = 1'b1; flush = 1'b0; prev_done = 1'b0; next_stall = 1'b0;
        pc_in = '0; pcv_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", 128'(addr), 128'(0));
        chk("rst_outputs", 128'({pc_out, pcv_out, ins_out, iv_out}), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back PCs with 1-cycle memory
        emit_cyc.delete();
        send(32'h0, 1'b1);
        c0 = cyc;
        send(32'h4, 1'b1);
        send(32'h8, 1'b1);
        wait_drain("t1_drain");
        chk("t1_emit_count", 128'(emit_cyc.size()), 128'(3));
        chk("t1_emit0_cycle", 128'(emit_cyc[0]), 128'(c0 + 1));
        chk("t1_emit1_cycle", 128'(emit_cyc[1]), 128'(c0 + 2));
        chk("t1_emit2_cycle", 128'(emit_cyc[2]), 128'(c0 + 3));

        // Decode stalls for 10 cycles: only DEPTH fetches, then the PC stage is held
        next_stall = 1'b1;
        a0 = act_done_cnt;
        fork
            begin
                for (int i = 0; i < 5; i++) send(32'h200 + 32'(4 * i), 1'b1);
            end
            begin
                repeat (10) @(negedge clk);
                chk("t2_fetch_pairs", 128'(act_done_cnt - a0), 128'(DEPTH));
                chk("t2_stall_prev", 128'(stall_prev), 128'(1));
                chk("t2_head_pc", 128'(pc_out), 128'(32'h200));
                chk("t2_done_next", 128'(done_next), 128'(1));
                @(posedge clk);
                #1 next_stall = 1'b0;
            end
        join
        wait_drain("t2_drain");

        // Bubble in the middle of valid PCs never reaches memory
        a0 = act_done_cnt;
        send(32'h3C, 1'b1);
        send(32'h40, 1'b0);
        send(32'h44, 1'b1);
        wait_drain("t3_drain");
        chk("t3_fetch_pairs", 128'(act_done_cnt - a0), 128'(2));

        // Slow memory: request held for 5 cycles
        mem_lat = 5;
        send(32'h100, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_activate", 128'(act), 128'(1));
            chk("t4_addr", 128'(addr), 128'(32'h100));
            chk("t4_stall_prev", 128'(stall_prev), 128'(1));
        end
        wait_drain("t4_drain");
        chk("t4_activate_cycles", 128'(last_run), 128'(5));
        mem_lat = 1;

        // Flush coinciding with fetch_done while two entries are queued
        next_stall = 1'b1;
        send(32'h300, 1'b1);
        send(32'h304, 1'b1);
        mem_lat = 3;
        send(32'h308, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("t5_done_next", 128'(done_next), 128'(0));
        chk("t5_activate", 128'(act), 128'(0));
        chk("t5_outputs", 128'({pc_out, pcv_out, ins_out, iv_out}), 128'(0));
        chk("t5_stall_prev", 128'(stall_prev), 128'(0));
        @(posedge clk);
        #1 next_stall = 1'b0;
        mem_lat = 1;
        send(32'h30C, 1'b1);
        wait_drain("t5_drain");

        // Reset mid-fetch with queued entries
        next_stall = 1'b1;
        send(32'h400, 1'b1);
        send(32'h404, 1'b1);
        mem_lat = 4;
        send(32'h408, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_done_next", 128'(done_next), 128'(0));
        chk("t6_stall_prev", 128'(stall_prev), 128'(0));
        chk("t6_activate", 128'(act), 128'(0));
        chk("t6_addr", 128'(addr), 128'(0));
        chk("t6_outputs", 128'({pc_out, pcv_out, ins_out, iv_out}), 128'(0));
        @(posedge clk);
        #1 next_stall = 1'b0;
        mem_lat = 1;

        // Randomized traffic with random memory latency, decode stalls and flushes
        mem_rand = 1;
        a0 = act_done_cnt;
        for (int i = 0; i < 600; i++) begin
            prev_done  = ($urandom_range(0, 3) != 0);
            pc_in      = $urandom & 32'hFFFF_FFFC;
            pcv_in     = ($urandom_range(0, 4) != 0);
            next_stall = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        next_stall = 1'b0;
        wait_drain("rand_drain");
        chk("rand_fetch_q_empty", 128'(fetch_q.size()), 128'(0));
        if (act_done_cnt - a0 < 20) fail_bound("rand_progress");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
